// File: rtl/fft_subcarrier_demap_if.sv
// Handshake bundle for the subcarrier demapper.
// Input stream: data_in/valid_in/ready_out. Output stream: data_out/valid_out/last_out/ready_in.
// master = the surrounding logic (FFT upstream + downstream consumer); slave = the demapper.
interface fft_subcarrier_demap_if #(
  parameter int DW = 32
);
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          last_out;
  logic          ready_in;

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, last_out
  );

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, last_out
  );
endinterface

// File: rtl/fft_subcarrier_demap.sv
// Receive-side subcarrier demapper placed after the N-point FFT.
// Writes one bit-reversed FFT frame into a ping-pong bank, then streams the
// active subcarriers out in natural frequency order: negative band, then
// positive band, skipping DC and guard bins.
// Optional build macro: DEMAP_INCLUDE_DC_EN -- when defined, the DC bin is
// emitted between the two bands (M+1 outputs per frame).
module fft_subcarrier_demap #(
  parameter int N     = 128,
  parameter int LOG2N = 7,
  parameter int M     = 62,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  fft_subcarrier_demap_if.slave      bus
);

  // Output frame geometry
  localparam int HALF = M / 2;
`ifdef DEMAP_INCLUDE_DC_EN
  localparam int OUT_CNT = M + 1;
`else
  localparam int OUT_CNT = M;
`endif
  localparam int LAST_IDX_I = OUT_CNT - 1;
  localparam int NEG_BASE_I = N - HALF;
  localparam int WR_LAST_I  = N - 1;

  localparam logic [LOG2N-1:0] LAST_IDX = LAST_IDX_I[LOG2N-1:0];
  localparam logic [LOG2N-1:0] NEG_BASE = NEG_BASE_I[LOG2N-1:0];
  localparam logic [LOG2N-1:0] HALF_L   = HALF[LOG2N-1:0];
  localparam logic [LOG2N-1:0] WR_LAST  = WR_LAST_I[LOG2N-1:0];

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Output index k -> FFT bin. Negative band first, then positive band.
  function automatic logic [LOG2N-1:0] bin_of(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] b;
    if (k < HALF_L) begin
      b = k + NEG_BASE;
    end
`ifdef DEMAP_INCLUDE_DC_EN
    else if (k == HALF_L) begin
      b = '0;
    end else begin
      b = k - HALF_L;
    end
`else
    else begin
      b = k - HALF_L + 1'b1;
    end
`endif
    return b;
  endfunction

  // Both banks live in one array; the top address bit selects the bank.
  logic [DW-1:0]    mem [0:2*N-1];

  // Write side
  logic             wr_bank_reg;
  logic [LOG2N-1:0] wr_cnt_reg;
  logic [LOG2N-1:0] wr_addr_rev;
  logic             wr_fire;
  logic [1:0]       set_mask;

  // Shared bank status
  logic [1:0]       full_reg;
  logic [1:0]       clr_mask;

  // Read side
  state_t           state_reg;
  state_t           state_next;
  logic             rd_bank_reg;
  logic             rd_bank_next;
  logic [LOG2N-1:0] rd_cnt_reg;
  logic [LOG2N-1:0] rd_cnt_next;
  logic [LOG2N-1:0] rd_cnt_inc;
  logic             valid_reg;
  logic             valid_next;
  logic             last_reg;
  logic             last_next;
  logic [DW-1:0]    data_out_reg;
  logic             load_en;
  logic             load_bank;
  logic [LOG2N-1:0] load_idx;
  logic [LOG2N:0]   rd_addr;

  // Input bins arrive bit-reversed; reversing the counter stores each at its true bin.
  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
      assign wr_addr_rev[gi] = wr_cnt_reg[LOG2N-1-gi];
    end
  endgenerate

  // Ready depends only on registered bank status.
  assign bus.ready_out = ~full_reg[wr_bank_reg];
  assign wr_fire       = bus.valid_in & bus.ready_out;

  assign bus.data_out  = data_out_reg;
  assign bus.valid_out = valid_reg;
  assign bus.last_out  = last_reg;

  assign rd_cnt_inc    = rd_cnt_reg + 1'b1;
  assign rd_addr       = {load_bank, bin_of(load_idx)};

  // Mark the write bank full on the final sample of a frame.
  always_comb begin
    set_mask = '0;
    if (wr_fire && (wr_cnt_reg == WR_LAST)) begin
      set_mask[wr_bank_reg] = 1'b1;
    end
  end

  // Write counter and bank pointer; counter wraps naturally at N.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_reg  <= '0;
      wr_bank_reg <= 1'b0;
    end else if (wr_fire) begin
      wr_cnt_reg <= wr_cnt_reg + 1'b1;
      if (wr_cnt_reg == WR_LAST) begin
        wr_bank_reg <= ~wr_bank_reg;
      end
    end
  end

  // Sample storage write port (contents are not cleared by reset).
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank_reg, wr_addr_rev}] <= bus.data_in;
    end
  end

  // Full flags: a set on one bank and a clear on the other can coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg <= '0;
    end else begin
      full_reg <= (full_reg & ~clr_mask) | set_mask;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Read FSM next state, output-register load control and bank release.
  always_comb begin
    state_next   = state_reg;
    rd_bank_next = rd_bank_reg;
    rd_cnt_next  = rd_cnt_reg;
    valid_next   = valid_reg;
    last_next    = last_reg;
    load_en      = 1'b0;
    load_bank    = rd_bank_reg;
    load_idx     = rd_cnt_inc;
    clr_mask     = '0;

    case (state_reg)
      IDLE: begin
        if (full_reg[rd_bank_reg]) begin
          load_en     = 1'b1;
          load_idx    = '0;
          rd_cnt_next = '0;
          valid_next  = 1'b1;
          last_next   = 1'b0;
          state_next  = STREAM;
        end
      end

      STREAM: begin
        if (!valid_reg || bus.ready_in) begin
          if (valid_reg && last_reg) begin
            // Final subcarrier leaves: release the bank and move on.
            clr_mask[rd_bank_reg] = 1'b1;
            rd_bank_next          = ~rd_bank_reg;
            rd_cnt_next           = '0;
            if (full_reg[~rd_bank_reg]) begin
              // Next frame already waiting: start it without a bubble.
              load_en    = 1'b1;
              load_bank  = ~rd_bank_reg;
              load_idx   = '0;
              valid_next = 1'b1;
              last_next  = 1'b0;
            end else begin
              valid_next = 1'b0;
              last_next  = 1'b0;
              state_next = IDLE;
            end
          end else begin
            load_en     = 1'b1;
            load_idx    = rd_cnt_inc;
            rd_cnt_next = rd_cnt_inc;
            valid_next  = 1'b1;
            last_next   = (rd_cnt_inc == LAST_IDX);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read-side control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank_reg <= 1'b0;
      rd_cnt_reg  <= '0;
      valid_reg   <= 1'b0;
      last_reg    <= 1'b0;
    end else begin
      rd_bank_reg <= rd_bank_next;
      rd_cnt_reg  <= rd_cnt_next;
      valid_reg   <= valid_next;
      last_reg    <= last_next;
    end
  end

  // Registered memory read doubles as the output data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_reg <= '0;
    end else if (load_en) begin
      data_out_reg <= mem[rd_addr];
    end
  end

endmodule

// File: doc/fft_subcarrier_demap.md
Name: fft_subcarrier_demap

Overview:
Receive-side subcarrier demapper that sits directly after the 128-point FFT. It accepts one FFT frame of N samples in bit-reversed order and extracts the M active subcarriers. They leave in natural frequency order: negative band first, then positive band, with DC and guard bins discarded. Ping-pong buffering lets one frame be written while the previous frame is read out.

Parameters:
N, 128, FFT size; power of two.
LOG2N, 7, log2(N); bit-reversal width and counter width.
M, 62, active subcarriers; even, M/2 < N/2.
DW, 32, sample width (signed, packed I/Q, passed through untouched).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
data_in  in  DW  FFT output sample, bit-reversed order
valid_in  in  1  data_in valid
ready_out  out  1  block can accept data_in
data_out  out  DW  demapped subcarrier sample
valid_out  out  1  data_out valid
last_out  out  1  marks final subcarrier of a frame; qualified by valid_out
ready_in  in  1  downstream can accept data_out

Behaviour:
- Storage: two banks of N x DW words (bank0, bank1), plus per-bank full flag, wr_bank, rd_bank, wr_cnt[LOG2N-1:0] and rd_cnt (0..M-1).
- Input handshake: a sample transfers when valid_in && ready_out.
  - ready_out = !full[wr_bank], derived from registers only; no combinational path from valid_in.
  - A transfer writes data_in to bank[wr_bank][bitrev(wr_cnt)], then wr_cnt increments.
- Input frame end: a transfer with wr_cnt==N-1 sets full[wr_bank] and toggles wr_bank; wr_cnt wraps to 0.
- Output mapping, for rd_cnt = k:
  - bin = N-M/2+k when k < M/2.
  - bin = k-M/2+1 otherwise.
  - Defaults give bins 97..127 then 1..31. Bin 0 (DC) and bins M/2+1..N-M/2-1 (guards) are never output.
- Read FSM, states IDLE and STREAM:
  - IDLE: when full[rd_bank]=1, load data_out with bin(0) and go to STREAM. valid_out rises the following cycle.
  - STREAM: output register loads bin(rd_cnt) when !valid_out || ready_in. data_out, valid_out and last_out are held stable while valid_out && !ready_in.
  - last_out=1 with the sample at k=M-1.
  - When that sample transfers (valid_out && ready_in && last_out): clear full[rd_bank], toggle rd_bank, reset rd_cnt to 0, return to IDLE. If the other bank is already full, go back-to-back with no bubble: the next frame's bin(0) loads in the same cycle.
- Latency: last input transfer at cycle t -> full set at t+1 -> valid_out=1 with first sample at t+2.
- Boundary conditions:
  - Both banks full: ready_out=0 until the read side frees a bank.
  - Bank freed in cycle t: ready_out rises at t+1.
  - Set of full on one bank and clear on the other in the same cycle are both honoured.
- Throughput: with ready_in held at 1, output takes M cycles per frame against N input cycles, so ready_out never deasserts in steady state.
- Reset, including mid-frame:
  - Outputs: ready_out=1 the cycle after rst falls, valid_out=0, last_out=0, data_out=0.
  - State: wr_cnt=0, rd_cnt=0, wr_bank=rd_bank=0, full flags=0, FSM=IDLE.
  - Partial frames are discarded. Memory contents need not be cleared.

Optional Feature:
Macro: DEMAP_INCLUDE_DC_EN.
- Defined: DC bin is emitted between the bands, giving M+1 outputs per frame: bins N-M/2..N-1, 0, 1..M/2 (defaults: 97..127, 0, 1..31). last_out is on output index M.
- Undefined: exactly M outputs as specified above.

Test Plan:
- Single frame: input position i carries value bitrev(i), so bin b holds b; ready_in=1 -> outputs 97,98,...,127,1,...,31. 62 beats, last_out only on 31, valid_out first high 2 cycles after the 128th input transfer.
- Three back-to-back frames, frame f bin b = f*256+b, valid_in and ready_in constant 1 -> ready_out never drops after reset release. Outputs are three correctly ordered 62-sample frames with no cross-frame mixing.
- Backpressure: ready_in=0 throughout, send frames -> after 256 transfers ready_out=0 and data_out holds 97 with valid_out=1. Raising ready_in drains frame 0; ready_out returns 1 one cycle after its last_out beat.
- Random ready_in (50%) and valid_in (70%) over 10 frames -> output stream equals the golden model, with no data change while valid_out && !ready_in.
- Reset asserted after 60 input samples -> after reset, valid_out=0, ready_out=1. A fresh full frame yields only that frame's values.
- With DEMAP_INCLUDE_DC_EN, single frame as in the first scenario -> 63 outputs 97..127,0,1..31, last_out on 31.
